// File: rtl/mem_load_pkg.sv
// Shared types for the load-return stage: size/mode encodings and the queued per-load
// control fields.
package mem_load_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } load_size_t;

  // 2'b11 is reserved.
  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10
  } load_mode_t;

  // Width-independent part of a queue entry; offset/old/tag live in parameter-sized arrays.
  typedef struct packed {
    load_size_t size;
    logic       extend;
    load_mode_t mode;
  } load_ctrl_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load data formatter: lane select with sign/zero extension, or an
// unaligned LEFT/RIGHT byte merge with the old destination value.
module load_formatter
  import mem_load_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  load_size_t                          size,
  input  logic                                extend,
  input  load_mode_t                          mode,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]     offset,
  input  logic [DATA_WIDTH-1:0]               old,
  input  logic [DATA_WIDTH-1:0]               data,
  output logic [DATA_WIDTH-1:0]               result
);

  localparam int unsigned OW = $clog2(DATA_WIDTH / 8);
  localparam logic [DATA_WIDTH-1:0] Ones = '1;

  logic [OW-1:0]         lane_off;
  logic [DATA_WIDTH-1:0] field_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  sign_bit;
  logic [DATA_WIDTH-1:0] normal_res;
  logic [DATA_WIDTH-1:0] left_mask;
  logic [DATA_WIDTH-1:0] left_res;
  logic [DATA_WIDTH-1:0] right_mask;
  logic [DATA_WIDTH-1:0] right_res;

  // Align the offset down to the access size; WORD on a 32-bit path collapses to lane 0.
  always_comb begin
    lane_off   = '0;
    field_mask = Ones;
    case (size)
      BYTE: begin
        lane_off   = offset;
        field_mask = Ones >> (DATA_WIDTH - 8);
      end
      HALF: begin
        lane_off   = offset & ~OW'(1);
        field_mask = Ones >> (DATA_WIDTH - 16);
      end
      WORD: begin
        lane_off   = offset & ~OW'(3);
        field_mask = Ones >> (DATA_WIDTH - 32);
      end
      default: begin
        lane_off   = '0;
        field_mask = Ones;
      end
    endcase
  end

  assign shifted = data >> {lane_off, 3'b000};

  always_comb begin
    sign_bit = 1'b0;
    case (size)
      BYTE:    sign_bit = extend & shifted[7];
      HALF:    sign_bit = extend & shifted[15];
      WORD:    sign_bit = extend & shifted[31];
      default: sign_bit = 1'b0;
    endcase
  end

  assign normal_res = (shifted & field_mask) | ({DATA_WIDTH{sign_bit}} & ~field_mask);

  // LEFT places data bytes [o:0] at the top; B-1-o is simply ~o in OW bits.
  assign left_mask  = Ones << {~offset, 3'b000};
  assign left_res   = (data << {~offset, 3'b000}) | (old & ~left_mask);
  assign right_mask = Ones >> {offset, 3'b000};
  assign right_res  = (data >> {offset, 3'b000}) | (old & ~right_mask);

  always_comb begin
    result = normal_res;
    case (mode)
      LEFT:    result = left_res;
      RIGHT:   result = right_res;
      default: result = normal_res;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Load-return stage: in-order queue of outstanding load metadata, discard counter for
// flushed loads, and a registered formatted result toward writeback.
module mem_load_unit
  import mem_load_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [1:0]                        req_size,
  input  logic                              req_extend,
  input  logic [1:0]                        req_mode,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   req_offset,
  input  logic [DATA_WIDTH-1:0]             req_old,
  input  logic [TAG_WIDTH-1:0]              req_tag,
  input  logic                              resp_valid,
  output logic                              resp_ready,
  input  logic [DATA_WIDTH-1:0]             resp_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [TAG_WIDTH-1:0]              out_tag
);

  localparam int unsigned OW = $clog2(DATA_WIDTH / 8);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  load_ctrl_t            ctrl_q   [DEPTH];
  logic [OW-1:0]         offset_q [DEPTH];
  logic [DATA_WIDTH-1:0] old_q    [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q    [DEPTH];

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d, discard_q, discard_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

  logic                  discarding, push, pop, drop;
  logic [DATA_WIDTH-1:0] fmt_result;

  assign discarding = (discard_q != '0);
  assign req_ready  = !flush && ((count_q + discard_q) < CW'(DEPTH));
  assign resp_ready = discarding || ((count_q != '0) && (!out_valid_q || out_ready));
  assign push       = req_valid && req_ready;
  assign pop        = resp_valid && resp_ready && !discarding;
  assign drop       = resp_valid && resp_ready && discarding;

  load_formatter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_formatter (
    .size   (ctrl_q[head_q].size),
    .extend (ctrl_q[head_q].extend),
    .mode   (ctrl_q[head_q].mode),
    .offset (offset_q[head_q]),
    .old    (old_q[head_q]),
    .data   (resp_data),
    .result (fmt_result)
  );

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    discard_d   = discard_q - CW'(drop);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;

    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = fmt_result;
      out_tag_d   = tag_q[head_q];
    end

    // Every load still queued after this cycle's pop turns into a response to discard.
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      discard_d   = discard_q - CW'(drop) + count_q - CW'(pop);
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      discard_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      discard_q   <= discard_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ctrl_q[tail_q]   <= '{size:   load_size_t'(req_size),
                            extend: req_extend,
                            mode:   load_mode_t'(req_mode)};
      offset_q[tail_q] <= req_offset;
      old_q[tail_q]    <= req_old;
      tag_q[tail_q]    <= req_tag;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

  a_reserved_mode: assert property (@(posedge clk) disable iff (reset)
    push |-> (req_mode != 2'b11));
  a_dword_on_32: assert property (@(posedge clk) disable iff (reset)
    (push && (DATA_WIDTH == 32)) |-> (req_size != 2'b11));
  a_outstanding: assert property (@(posedge clk) disable iff (reset)
    (count_q + discard_q) <= CW'(DEPTH));

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit: a 32-bit and a 64-bit instance share clock and reset.
module tb_mem_load_unit;
  import mem_load_pkg::*;

  logic clk = 1'b0;
  logic reset, flush;

  logic        req_valid  [2];
  logic [1:0]  req_size   [2];
  logic        req_extend [2];
  logic [1:0]  req_mode   [2];
  logic [2:0]  req_offset [2];
  logic [63:0] req_old    [2];
  logic [4:0]  req_tag    [2];
  logic        resp_valid [2];
  logic [63:0] resp_data  [2];
  logic        out_ready  [2];

  logic        a_req_ready, a_resp_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [4:0]  a_out_tag;
  logic        b_req_ready, b_resp_ready, b_out_valid;
  logic [63:0] b_out_data;
  logic [4:0]  b_out_tag;

  int compared = 0;
  int mismatched = 0;
  logic [68:0] sb_a [$];
  logic [68:0] sb_b [$];
  logic [68:0] e_a, e_b;

  always #5 clk = ~clk;

  mem_load_unit #(.DATA_WIDTH(32), .DEPTH(4), .TAG_WIDTH(5)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid[0]),
    .req_ready  (a_req_ready),
    .req_size   (req_size[0]),
    .req_extend (req_extend[0]),
    .req_mode   (req_mode[0]),
    .req_offset (req_offset[0][1:0]),
    .req_old    (req_old[0][31:0]),
    .req_tag    (req_tag[0]),
    .resp_valid (resp_valid[0]),
    .resp_ready (a_resp_ready),
    .resp_data  (resp_data[0][31:0]),
    .out_valid  (a_out_valid),
    .out_ready  (out_ready[0]),
    .out_data   (a_out_data),
    .out_tag    (a_out_tag)
  );

  mem_load_unit #(.DATA_WIDTH(64), .DEPTH(4), .TAG_WIDTH(5)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .flush      (1'b0),
    .req_valid  (req_valid[1]),
    .req_ready  (b_req_ready),
    .req_size   (req_size[1]),
    .req_extend (req_extend[1]),
    .req_mode   (req_mode[1]),
    .req_offset (req_offset[1]),
    .req_old    (req_old[1]),
    .req_tag    (req_tag[1]),
    .resp_valid (resp_valid[1]),
    .resp_ready (b_resp_ready),
    .resp_data  (resp_data[1]),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready[1]),
    .out_data   (b_out_data),
    .out_tag    (b_out_tag)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  function automatic logic req_rdy(input int w);
    return (w == 0) ? a_req_ready : b_req_ready;
  endfunction

  function automatic logic resp_rdy(input int w);
    return (w == 0) ? a_resp_ready : b_resp_ready;
  endfunction

  function automatic logic ovalid(input int w);
    return (w == 0) ? a_out_valid : b_out_valid;
  endfunction

  // Scoreboard pop on the result handshake, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset && a_out_valid && out_ready[0]) begin
      if (sb_a.size() == 0) check("a_spurious_out", 64'(a_out_valid), 64'd0);
      else begin
        e_a = sb_a.pop_front();
        check("a_out_data", 64'(a_out_data), e_a[63:0]);
        check("a_out_tag", 64'(a_out_tag), 64'(e_a[68:64]));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_out_valid && out_ready[1]) begin
      if (sb_b.size() == 0) check("b_spurious_out", 64'(b_out_valid), 64'd0);
      else begin
        e_b = sb_b.pop_front();
        check("b_out_data", b_out_data, e_b[63:0]);
        check("b_out_tag", 64'(b_out_tag), 64'(e_b[68:64]));
      end
    end
  end

  task automatic issue(input int w, input logic [1:0] size, input logic ext,
                       input logic [1:0] mode, input logic [2:0] off,
                       input logic [63:0] old, input logic [4:0] tag);
    int n = 0;
    @(posedge clk); #1;
    req_valid[w]  = 1'b1;
    req_size[w]   = size;
    req_extend[w] = ext;
    req_mode[w]   = mode;
    req_offset[w] = off;
    req_old[w]    = old;
    req_tag[w]    = tag;
    @(negedge clk);
    while (!req_rdy(w) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", 64'(req_rdy(w)), 64'd1);
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
  endtask

  task automatic respond(input int w, input logic [63:0] data, input logic expect_out,
                         input logic [63:0] exp_data, input logic [4:0] exp_tag);
    int n = 0;
    @(posedge clk); #1;
    if (expect_out) begin
      if (w == 0) sb_a.push_back({exp_tag, exp_data});
      else        sb_b.push_back({exp_tag, exp_data});
    end
    resp_valid[w] = 1'b1;
    resp_data[w]  = data;
    @(negedge clk);
    while (!resp_rdy(w) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("resp_ready", 64'(resp_rdy(w)), 64'd1);
    @(posedge clk); #1;
    resp_valid[w] = 1'b0;
    @(negedge clk);
    check(expect_out ? "latency_out_valid" : "dropped_out_valid", 64'(ovalid(w)),
          64'(expect_out));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] held_data;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_size[i] = '0; req_extend[i] = 1'b0; req_mode[i] = '0;
      req_offset[i] = '0; req_old[i] = '0; req_tag[i] = '0; resp_valid[i] = 1'b0;
      resp_data[i] = '0; out_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_out_data", 64'(a_out_data), 64'd0);
    check("rst_a_out_tag", 64'(a_out_tag), 64'd0);
    check("rst_a_req_ready", 64'(a_req_ready), 64'd1);
    check("rst_a_resp_ready", 64'(a_resp_ready), 64'd0);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    check("rst_b_req_ready", 64'(b_req_ready), 64'd1);

    // Normal formatting and merges on the 32-bit path.
    issue(0, BYTE, 1'b1, NORMAL, 3'd3, 64'd0, 5'd5);
    respond(0, 64'h8012_3456, 1'b1, 64'hFFFF_FF80, 5'd5);
    issue(0, HALF, 1'b0, NORMAL, 3'd2, 64'd0, 5'd6);
    respond(0, 64'hBEEF_1234, 1'b1, 64'h0000_BEEF, 5'd6);
    issue(0, WORD, 1'b1, NORMAL, 3'd0, 64'd0, 5'd7);
    respond(0, 64'hDEAD_BEEF, 1'b1, 64'hDEAD_BEEF, 5'd7);
    issue(0, BYTE, 1'b0, NORMAL, 3'd1, 64'd0, 5'd9);
    respond(0, 64'h12F4_5678, 1'b1, 64'h0000_0056, 5'd9);
    issue(0, HALF, 1'b1, NORMAL, 3'd0, 64'd0, 5'd10);
    respond(0, 64'h0000_8001, 1'b1, 64'hFFFF_8001, 5'd10);
    issue(0, BYTE, 1'b0, LEFT, 3'd1, 64'h1122_3344, 5'd11);
    respond(0, 64'hAABB_CCDD, 1'b1, 64'hCCDD_3344, 5'd11);
    issue(0, BYTE, 1'b0, RIGHT, 3'd1, 64'h1122_3344, 5'd12);
    respond(0, 64'hAABB_CCDD, 1'b1, 64'h11AA_BBCC, 5'd12);
    issue(0, WORD, 1'b1, LEFT, 3'd0, 64'h1122_3344, 5'd13);
    respond(0, 64'hAABB_CCDD, 1'b1, 64'hDD22_3344, 5'd13);
    issue(0, HALF, 1'b1, LEFT, 3'd3, 64'h1122_3344, 5'd14);
    respond(0, 64'hAABB_CCDD, 1'b1, 64'hAABB_CCDD, 5'd14);
    issue(0, BYTE, 1'b1, RIGHT, 3'd3, 64'h1122_3344, 5'd15);
    respond(0, 64'hAABB_CCDD, 1'b1, 64'h1122_33AA, 5'd15);

    // Fill the queue, then hold writeback off.
    for (int k = 1; k <= 4; k++) issue(0, BYTE, 1'b0, NORMAL, 3'(k - 1), 64'd0, 5'(k));
    @(negedge clk);
    check("full_req_ready", 64'(a_req_ready), 64'd0);
    @(posedge clk); #1 out_ready[0] = 1'b0;
    respond(0, 64'h0000_0011, 1'b1, 64'h11, 5'd1);
    check("bp_resp_ready", 64'(a_resp_ready), 64'd0);
    held_data = a_out_data;
    @(negedge clk);
    check("bp_out_valid_hold", 64'(a_out_valid), 64'd1);
    check("bp_out_data_hold", 64'(a_out_data), 64'(held_data));
    check("bp_out_tag_hold", 64'(a_out_tag), 64'd1);
    @(posedge clk); #1 out_ready[0] = 1'b1;
    for (int k = 2; k <= 4; k++)
      respond(0, 64'(32'(k * 17) << ((k - 1) * 8)), 1'b1, 64'(k * 17), 5'(k));

    // Flush with a held result and three loads in flight.
    @(posedge clk); #1 out_ready[0] = 1'b0;
    issue(0, BYTE, 1'b0, NORMAL, 3'd0, 64'd0, 5'd13);
    respond(0, 64'h0000_005A, 1'b1, 64'h5A, 5'd13);
    for (int k = 0; k < 3; k++) issue(0, BYTE, 1'b0, NORMAL, 3'd0, 64'd0, 5'(20 + k));
    @(posedge clk); #1;
    flush = 1'b1;
    req_valid[0] = 1'b1;
    req_tag[0] = 5'd31;
    @(negedge clk);
    check("flush_req_ready", 64'(a_req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid[0] = 1'b0;
    sb_a.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(a_out_valid), 64'd0);
    check("discard_resp_ready", 64'(a_resp_ready), 64'd1);
    out_ready[0] = 1'b1;
    for (int k = 0; k < 3; k++) respond(0, 64'h0000_00EE, 1'b0, 64'd0, 5'd0);
    check("post_discard_resp_ready", 64'(a_resp_ready), 64'd0);
    issue(0, BYTE, 1'b0, NORMAL, 3'd2, 64'd0, 5'd25);
    respond(0, 64'h0033_0000, 1'b1, 64'h33, 5'd25);

    // 64-bit path.
    issue(1, WORD, 1'b1, NORMAL, 3'd4, 64'd0, 5'd3);
    respond(1, 64'h8000_0001_1234_5678, 1'b1, 64'hFFFF_FFFF_8000_0001, 5'd3);
    issue(1, DWORD, 1'b0, NORMAL, 3'd0, 64'd0, 5'd4);
    respond(1, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0123_4567_89AB_CDEF, 5'd4);
    issue(1, BYTE, 1'b1, NORMAL, 3'd7, 64'd0, 5'd5);
    respond(1, 64'h9000_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FF90, 5'd5);
    issue(1, BYTE, 1'b0, RIGHT, 3'd2, 64'h1111_2222_3333_4444, 5'd6);
    respond(1, 64'hAABB_CCDD_EEFF_0011, 1'b1, 64'h1111_AABB_CCDD_EEFF, 5'd6);

    // Reset in the middle of traffic.
    @(posedge clk); #1 out_ready[1] = 1'b0;
    issue(1, BYTE, 1'b0, NORMAL, 3'd0, 64'd0, 5'd7);
    issue(1, BYTE, 1'b0, NORMAL, 3'd0, 64'd0, 5'd8);
    respond(1, 64'h77, 1'b1, 64'h77, 5'd7);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb_b.delete();
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(b_out_valid), 64'd0);
    check("midrst_req_ready", 64'(b_req_ready), 64'd1);
    check("midrst_resp_ready", 64'(b_resp_ready), 64'd0);

    repeat (2) @(negedge clk);
    check("sb_a_drained", 64'(sb_a.size()), 64'd0);
    check("sb_b_drained", 64'(sb_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
